// File: rtl/inst_reg_pkg.sv
// Shared encodings and widths for the IR/register-file front-end.
// Select codes for read/write address muxes and writeback source.
package inst_reg_pkg;

  localparam int REG_W  = 16;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 16;

  localparam logic [ADDR_W-1:0] LINK_REG = 4'hF;

  localparam logic [1:0] R1_IR11_8  = 2'b00;
  localparam logic [1:0] R1_IR7_4   = 2'b01;
  localparam logic [1:0] R1_IR3_0   = 2'b10;
  localparam logic [1:0] R1_IR15_12 = 2'b11;

  localparam logic R2_IR7_4 = 1'b0;
  localparam logic R2_IR3_0 = 1'b1;

  localparam logic [1:0] WA_IR11_8 = 2'b00;
  localparam logic [1:0] WA_IR7_4  = 2'b01;
  localparam logic [1:0] WA_IR3_0  = 2'b10;
  localparam logic [1:0] WA_LINK   = 2'b11;

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_MDR  = 2'b01;
  localparam logic [1:0] WD_PC   = 2'b10;
  localparam logic [1:0] WD_IMM8 = 2'b11;

  function automatic logic [REG_W-1:0] zext8(
    input logic [7:0] v
  );
    return {8'h00, v};
  endfunction

endpackage

// File: rtl/reg_file_16x16.sv
// 16x16 register file: two combinational read ports,
// one synchronous write port, synchronous active-high reset.
module reg_file_16x16
  import inst_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [REG_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [REG_W-1:0]  rdata1,
  output logic [REG_W-1:0]  rdata2
);

  logic [REG_W-1:0] regs [NREGS];

  // Clear all entries on reset, otherwise single write when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see stored contents only; no bypass of the pending write.
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
  end

endmodule

// File: rtl/inst_reg_reg_file.sv
// Instruction register plus register file with operand/writeback muxes.
// Addresses and imm8 come from the IR value held before the clock edge.
module inst_reg_reg_file
  import inst_reg_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IRWrite,
  input  logic [REG_W-1:0]  MemData,
  input  logic [1:0]        RegOneRead,
  input  logic              RegTwoRead,
  input  logic [1:0]        RegWriteCode,
  input  logic [REG_W-1:0]  ALURegOut,
  input  logic [REG_W-1:0]  MemDataReg,
  input  logic [REG_W-1:0]  PC,
  input  logic [1:0]        MemToReg,
  input  logic              RegWrite,
  output logic [ADDR_W-1:0] IR15_12,
  output logic [ADDR_W-1:0] IR11_8,
  output logic [ADDR_W-1:0] IR7_4,
  output logic [ADDR_W-1:0] IR3_0,
  output logic [REG_W-1:0]  read1,
  output logic [REG_W-1:0]  read2
);

  logic [REG_W-1:0]  ir;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [ADDR_W-1:0] waddr;
  logic [REG_W-1:0]  wdata;

  // Latch the fetched word; reset wins over the load.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ir <= '0;
    end else if (IRWrite) begin
      ir <= MemData;
    end
  end

  assign IR15_12 = ir[15:12];
  assign IR11_8  = ir[11:8];
  assign IR7_4   = ir[7:4];
  assign IR3_0   = ir[3:0];

  // Select register addresses from IR fields.
  always_comb begin
    raddr1 = IR11_8;
    raddr2 = IR7_4;
    waddr  = IR11_8;
    unique case (RegOneRead)
      R1_IR11_8:  raddr1 = IR11_8;
      R1_IR7_4:   raddr1 = IR7_4;
      R1_IR3_0:   raddr1 = IR3_0;
      R1_IR15_12: raddr1 = IR15_12;
      default:    raddr1 = IR11_8;
    endcase
    raddr2 = (RegTwoRead == R2_IR3_0) ? IR3_0 : IR7_4;
    unique case (RegWriteCode)
      WA_IR11_8: waddr = IR11_8;
      WA_IR7_4:  waddr = IR7_4;
      WA_IR3_0:  waddr = IR3_0;
      WA_LINK:   waddr = LINK_REG;
      default:   waddr = IR11_8;
    endcase
  end

  // Pick the writeback source.
  always_comb begin
    wdata = ALURegOut;
    unique case (MemToReg)
      WD_ALU:  wdata = ALURegOut;
      WD_MDR:  wdata = MemDataReg;
      WD_PC:   wdata = PC;
      WD_IMM8: wdata = zext8(ir[7:0]);
      default: wdata = ALURegOut;
    endcase
  end

  reg_file_16x16 u_rf (
    .clk    (Clock),
    .rst    (Reset),
    .we     (RegWrite),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (read1),
    .rdata2 (read2)
  );

endmodule

// File: tb/tb_inst_reg_reg_file.sv
// Directed bench for the IR/register-file front-end.
// Expected values are hand-computed constants.
module tb_inst_reg_reg_file;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        IRWrite;
  logic [15:0] MemData;
  logic [1:0]  RegOneRead;
  logic        RegTwoRead;
  logic [1:0]  RegWriteCode;
  logic [15:0] ALURegOut;
  logic [15:0] MemDataReg;
  logic [15:0] PC;
  logic [1:0]  MemToReg;
  logic        RegWrite;
  logic [3:0]  IR15_12;
  logic [3:0]  IR11_8;
  logic [3:0]  IR7_4;
  logic [3:0]  IR3_0;
  logic [15:0] read1;
  logic [15:0] read2;

  int total = 0;
  int bad   = 0;

  logic [15:0] alu_v [7];
  logic [15:0] rd_ir [4];
  logic [15:0] rd_e1 [4];
  logic [15:0] rd_e2 [4];

  inst_reg_reg_file dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .IRWrite      (IRWrite),
    .MemData      (MemData),
    .RegOneRead   (RegOneRead),
    .RegTwoRead   (RegTwoRead),
    .RegWriteCode (RegWriteCode),
    .ALURegOut    (ALURegOut),
    .MemDataReg   (MemDataReg),
    .PC           (PC),
    .MemToReg     (MemToReg),
    .RegWrite     (RegWrite),
    .IR15_12      (IR15_12),
    .IR11_8       (IR11_8),
    .IR7_4        (IR7_4),
    .IR3_0        (IR3_0),
    .read1        (read1),
    .read2        (read2)
  );

  always #5 Clock = ~Clock;

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic ld_ir(input logic [15:0] v);
    IRWrite = 1'b1;
    MemData = v;
    tick();
    IRWrite = 1'b0;
  endtask

  task automatic wr(
    input logic [1:0]  code,
    input logic [1:0]  m2r,
    input logic [15:0] alu
  );
    RegWrite     = 1'b1;
    RegWriteCode = code;
    MemToReg     = m2r;
    ALURegOut    = alu;
    tick();
    RegWrite = 1'b0;
  endtask

  function automatic logic [15:0] irv();
    return {IR15_12, IR11_8, IR7_4, IR3_0};
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    alu_v = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1337,
              16'h0231, 16'hDEAD, 16'hBEEF};
    rd_ir = '{16'h0010, 16'h0230, 16'h0450, 16'h0670};
    rd_e1 = '{16'h1234, 16'hFFFF, 16'h0231, 16'hBEEF};
    rd_e2 = '{16'h0000, 16'h1337, 16'hDEAD, 16'h0000};

    Reset = 1'b1; IRWrite = 1'b1; MemData = 16'hFFFF;
    RegOneRead = 2'b00; RegTwoRead = 1'b0;
    RegWriteCode = 2'b00; MemToReg = 2'b00;
    ALURegOut = 16'h5555; MemDataReg = 16'h0;
    PC = 16'h0; RegWrite = 1'b1;
    tick();
    Reset = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0;

    chk("rst_ir", irv(), 16'h0000);
    for (int s = 0; s < 4; s++) begin
      RegOneRead = 2'(s);
      RegTwoRead = s[0];
      #1;
      chk("rst_r1", read1, 16'h0000);
      chk("rst_r2", read2, 16'h0000);
    end

    ld_ir(16'h1234);
    chk("ir_hi", {12'h0, IR15_12}, 16'h0001);
    chk("ir_118", {12'h0, IR11_8}, 16'h0002);
    chk("ir_74", {12'h0, IR7_4}, 16'h0003);
    chk("ir_30", {12'h0, IR3_0}, 16'h0004);
    MemData = 16'hABCD;
    tick();
    chk("ir_hold", irv(), 16'h1234);

    for (int n = 0; n < 7; n++) begin
      ld_ir({4'h0, 4'(n), 8'h00});
      wr(2'b00, 2'b00, alu_v[n]);
    end

    RegOneRead = 2'b00;
    RegTwoRead = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ld_ir(rd_ir[k]);
      chk("rd1", read1, rd_e1[k]);
      chk("rd2", read2, rd_e2[k]);
    end

    ld_ir(16'h08C3);
    MemDataReg = 16'hA5A5;
    PC = 16'h0042;
    wr(2'b00, 2'b01, 16'h0);
    chk("wb_mdr", read1, 16'hA5A5);
    wr(2'b00, 2'b10, 16'h0);
    chk("wb_pc", read1, 16'h0042);
    wr(2'b00, 2'b11, 16'h0);
    chk("wb_imm", read1, 16'h00C3);

    PC = 16'h0100;
    wr(2'b11, 2'b10, 16'h0);
    ld_ir(16'hF000);
    RegOneRead = 2'b11;
    #1;
    chk("link", read1, 16'h0100);

    ld_ir(16'h0CD0);
    wr(2'b01, 2'b00, 16'hCAFE);
    RegOneRead = 2'b00;
    RegTwoRead = 1'b0;
    #1;
    chk("wa74_c", read1, 16'h0000);
    chk("wa74_d", read2, 16'hCAFE);

    ld_ir(16'h000E);
    wr(2'b10, 2'b00, 16'hBABE);
    RegOneRead = 2'b10;
    RegTwoRead = 1'b1;
    #1;
    chk("wa30_r1", read1, 16'hBABE);
    chk("wa30_r2", read2, 16'hBABE);

    ld_ir(16'h0200);
    RegOneRead = 2'b00;
    RegWrite = 1'b1;
    RegWriteCode = 2'b00;
    MemToReg = 2'b00;
    ALURegOut = 16'h0123;
    #1;
    chk("nobyp_old", read1, 16'hFFFF);
    tick();
    RegWrite = 1'b0;
    chk("nobyp_new", read1, 16'h0123);

    ld_ir(16'h0300);
    IRWrite = 1'b1;
    MemData = 16'h0500;
    wr(2'b00, 2'b00, 16'h7777);
    IRWrite = 1'b0;
    chk("sim_ir", irv(), 16'h0500);
    chk("sim_r5", read1, 16'hDEAD);
    ld_ir(16'h0030);
    RegTwoRead = 1'b0;
    #1;
    chk("sim_r3", read2, 16'h7777);

    Reset = 1'b1;
    RegWrite = 1'b1;
    RegWriteCode = 2'b01;
    ALURegOut = 16'h9999;
    tick();
    Reset = 1'b0;
    RegWrite = 1'b0;
    ld_ir(16'h0030);
    chk("rst_pri", read2, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
